// File: rtl/pong_pkg.sv
// Shared types and constants for the ping-pong game control logic.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_TOP  = 2'b01;
    localparam logic [1:0] WIN_BOT  = 2'b10;

endpackage

// File: rtl/game_ctrl_btn_sync.sv
// Three-flop synchronizer for an asynchronous push button, followed by a
// rising-edge detector that emits a single-cycle pulse per press.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic [2:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[1:0], btn_i};
        prev_d = sync_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse_o = sync_q[2] & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Round/score sequencer for the ping-pong game: gates ball and paddles,
// counts points from miss events and declares a winner, stepping on fsync.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 120,
    parameter int POINT_FRAMES = 60,
    parameter int SCORE_W      = 4
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               start,
    input  logic               miss_top,
    input  logic               miss_bot,
    output logic               round_rst,
    output logic               play_en,
    output logic [SCORE_W-1:0] score_top,
    output logic [SCORE_W-1:0] score_bot,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win_score
        $error("game_ctrl: WIN_SCORE does not fit in SCORE_W bits");
    end
    if (SERVE_FRAMES < 1 || POINT_FRAMES < 1) begin : g_bad_frames
        $error("game_ctrl: SERVE_FRAMES and POINT_FRAMES must be at least 1");
    end

    logic start_pulse;

    btn_sync u_start_sync (
        .clk     (pixel_clk),
        .rst     (rst),
        .btn_i   (start),
        .pulse_o (start_pulse)
    );

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_top_q, score_top_d;
    logic [SCORE_W-1:0] score_bot_q, score_bot_d;
    logic [1:0]         winner_q, winner_d;
    logic               round_rst_q, round_rst_d;
    logic               play_en_q, play_en_d;
    logic               start_pend_q, start_pend_d;
    logic               mtop_pend_q, mtop_pend_d;
    logic               mbot_pend_q, mbot_pend_d;

    // Events arriving on the fsync cycle itself are folded in rather than lost.
    logic start_evt, mtop_evt, mbot_evt;

    always_comb begin
        start_evt = start_pend_q | start_pulse;
        mtop_evt  = mtop_pend_q | (miss_top && state_q == PLAY);
        mbot_evt  = mbot_pend_q | (miss_bot && state_q == PLAY);

        state_d      = state_q;
        cnt_d        = cnt_q;
        score_top_d  = score_top_q;
        score_bot_d  = score_bot_q;
        winner_d     = winner_q;
        start_pend_d = start_evt;
        mtop_pend_d  = mtop_evt;
        mbot_pend_d  = mbot_evt;

        if (fsync) begin
            start_pend_d = 1'b0;
            mtop_pend_d  = 1'b0;
            mbot_pend_d  = 1'b0;

            case (state_q)
                IDLE, GAMEOVER: begin
                    if (start_evt) begin
                        score_top_d = '0;
                        score_bot_d = '0;
                        winner_d    = WIN_NONE;
                        cnt_d       = '0;
                        state_d     = SERVE;
                    end
                end
                SERVE: begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    if (mtop_evt || mbot_evt) begin
                        cnt_d   = '0;
                        state_d = POINT;
                    end
                    // A simultaneous miss on both edges is a let: nobody scores.
                    if (mtop_evt && !mbot_evt) begin
                        score_bot_d = score_bot_q + 1'b1;
                        if (score_bot_d == WIN_VAL) begin
                            winner_d = WIN_BOT;
                            state_d  = GAMEOVER;
                        end
                    end else if (mbot_evt && !mtop_evt) begin
                        score_top_d = score_top_q + 1'b1;
                        if (score_top_d == WIN_VAL) begin
                            winner_d = WIN_TOP;
                            state_d  = GAMEOVER;
                        end
                    end
                end
                POINT: begin
                    if (cnt_q == POINT_LAST) begin
                        cnt_d   = '0;
                        state_d = SERVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        round_rst_d = (state_d == IDLE) || (state_d == SERVE);
        play_en_d   = (state_d == PLAY);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            score_top_q  <= '0;
            score_bot_q  <= '0;
            winner_q     <= WIN_NONE;
            round_rst_q  <= 1'b1;
            play_en_q    <= 1'b0;
            start_pend_q <= 1'b0;
            mtop_pend_q  <= 1'b0;
            mbot_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_top_q  <= score_top_d;
            score_bot_q  <= score_bot_d;
            winner_q     <= winner_d;
            round_rst_q  <= round_rst_d;
            play_en_q    <= play_en_d;
            start_pend_q <= start_pend_d;
            mtop_pend_q  <= mtop_pend_d;
            mbot_pend_q  <= mbot_pend_d;
        end
    end

    assign round_rst = round_rst_q;
    assign play_en   = play_en_q;
    assign score_top = score_top_q;
    assign score_bot = score_bot_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with short serve/point timers and a
// three-point game; fsync strobes every 16 pixel clocks.
module tb_game_ctrl;

    localparam int SCORE_W = 4;

    logic               clk;
    logic               rst;
    logic               fsync;
    logic               start;
    logic               miss_top;
    logic               miss_bot;
    logic               round_rst;
    logic               play_en;
    logic [SCORE_W-1:0] score_top;
    logic [SCORE_W-1:0] score_bot;
    logic [1:0]         winner;
    logic [2:0]         state;

    int tests = 0;
    int fails = 0;

    game_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (4),
        .POINT_FRAMES (2),
        .SCORE_W      (SCORE_W)
    ) dut (
        .pixel_clk (clk),
        .rst       (rst),
        .fsync     (fsync),
        .start     (start),
        .miss_top  (miss_top),
        .miss_bot  (miss_bot),
        .round_rst (round_rst),
        .play_en   (play_en),
        .score_top (score_top),
        .score_bot (score_bot),
        .winner    (winner),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int phase;
        phase = 0;
        fsync = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase == 15) ? 0 : phase + 1;
            fsync = (phase == 15);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge after the next fsync has been consumed.
    task automatic frame();
        int n;
        n = 0;
        @(negedge clk);
        while (fsync !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("fsync_wait", 8'(fsync), 8'd1);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press();
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_top();
        miss_top = 1'b1;
        @(negedge clk);
        miss_top = 1'b0;
    endtask

    task automatic pulse_bot();
        miss_bot = 1'b1;
        @(negedge clk);
        miss_bot = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        miss_top = 1'b0;
        miss_bot = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state",     8'(state),     8'd0);
        check("rst_score_top", 8'(score_top), 8'd0);
        check("rst_score_bot", 8'(score_bot), 8'd0);
        check("rst_winner",    8'(winner),    8'd0);
        check("rst_round_rst", 8'(round_rst), 8'd1);
        check("rst_play_en",   8'(play_en),   8'd0);

        frame();
        check("idle_no_start", 8'(state), 8'd0);

        // Start held for about 40 clocks spanning several fsyncs.
        start = 1'b1;
        frame();
        check("serve_entry",      8'(state),     8'd1);
        check("serve_round_rst",  8'(round_rst), 8'd1);
        check("serve_play_en",    8'(play_en),   8'd0);
        frame();
        repeat (8) @(negedge clk);
        start = 1'b0;
        frame();
        check("serve_f2", 8'(state), 8'd1);
        frame();
        check("serve_f3_state",   8'(state),   8'd1);
        check("serve_f3_play_en", 8'(play_en), 8'd0);
        frame();
        check("play_state",     8'(state),     8'd2);
        check("play_play_en",   8'(play_en),   8'd1);
        check("play_round_rst", 8'(round_rst), 8'd0);

        pulse_bot();
        frame();
        check("pt1_score_top", 8'(score_top), 8'd1);
        check("pt1_score_bot", 8'(score_bot), 8'd0);
        check("pt1_state",     8'(state),     8'd3);
        check("pt1_play_en",   8'(play_en),   8'd0);
        check("pt1_round_rst", 8'(round_rst), 8'd0);

        // Miss and start during POINT must be ignored.
        pulse_top();
        press();
        frame();
        check("point_hold_state", 8'(state),     8'd3);
        check("point_miss_drop",  8'(score_bot), 8'd0);
        frame();
        check("point_to_serve",   8'(state),     8'd1);
        check("point_round_rst",  8'(round_rst), 8'd1);

        frame();
        pulse_top();
        frame();
        check("serve_miss_state", 8'(state),     8'd1);
        check("serve_miss_drop",  8'(score_bot), 8'd0);
        frames(2);
        check("replay_state", 8'(state), 8'd2);

        press();
        frame();
        check("play_start_ign",  8'(state),     8'd2);
        check("play_no_stale",   8'(score_bot), 8'd0);
        frame();
        check("play_start_clr",  8'(state),     8'd2);

        // Let: both edges missed in one frame.
        pulse_top();
        pulse_bot();
        frame();
        check("let_state",     8'(state),     8'd3);
        check("let_score_top", 8'(score_top), 8'd1);
        check("let_score_bot", 8'(score_bot), 8'd0);
        frames(6);
        check("let_back_play", 8'(state), 8'd2);

        for (int i = 0; i < 3; i++) begin
            pulse_top();
            frame();
            check("win_score_bot", 8'(score_bot), 8'(i + 1));
            if (i < 2) begin
                check("win_point_state", 8'(state), 8'd3);
                frames(6);
                check("win_play_state", 8'(state), 8'd2);
            end
        end
        check("go_state",     8'(state),     8'd4);
        check("go_winner",    8'(winner),    8'd2);
        check("go_score_top", 8'(score_top), 8'd1);
        check("go_play_en",   8'(play_en),   8'd0);
        check("go_round_rst", 8'(round_rst), 8'd0);
        frame();
        check("go_hold_state", 8'(state),     8'd4);
        check("go_hold_score", 8'(score_bot), 8'd3);

        press();
        frame();
        check("restart_state",     8'(state),     8'd1);
        check("restart_score_top", 8'(score_top), 8'd0);
        check("restart_score_bot", 8'(score_bot), 8'd0);
        check("restart_winner",    8'(winner),    8'd0);
        check("restart_round_rst", 8'(round_rst), 8'd1);

        frames(4);
        check("r2_play", 8'(state), 8'd2);
        pulse_bot();
        frame();
        check("r2_score_top", 8'(score_top), 8'd1);
        frames(6);
        check("r2_replay", 8'(state), 8'd2);

        // Reset mid-PLAY with a miss pending.
        pulse_bot();
        rst = 1'b1;
        @(negedge clk);
        check("mrst_state",     8'(state),     8'd0);
        check("mrst_score_top", 8'(score_top), 8'd0);
        check("mrst_round_rst", 8'(round_rst), 8'd1);
        check("mrst_play_en",   8'(play_en),   8'd0);
        rst = 1'b0;
        frame();
        check("mrst_idle_hold", 8'(state),     8'd0);
        check("mrst_miss_lost", 8'(score_top), 8'd0);
        press();
        frame();
        check("mrst_start",       8'(state),     8'd1);
        check("mrst_start_score", 8'(score_top), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
